// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared types for the FP issue controller: operation encoding, controller
// state, the latched request record and the rounding-mode helper.
package fpu_issue_ctrl_pkg;

  typedef enum logic [4:0] {
    FPU_FMADD     = 5'd0,
    FPU_FMSUB     = 5'd1,
    FPU_FNMADD    = 5'd2,
    FPU_FNMSUB    = 5'd3,
    FPU_FADD      = 5'd4,
    FPU_FSUB      = 5'd5,
    FPU_FMUL      = 5'd6,
    FPU_FDIV      = 5'd7,
    FPU_FSQRT     = 5'd8,
    FPU_FSGNJ     = 5'd9,
    FPU_FMINMAX   = 5'd10,
    FPU_FCMP      = 5'd11,
    FPU_FCLASS    = 5'd12,
    FPU_FMV_X_F   = 5'd13,
    FPU_FMV_F_X   = 5'd14,
    FPU_FCVT_F2I  = 5'd15,
    FPU_FCVT_I2F  = 5'd16,
    FPU_FCVT_F2F  = 5'd17
  } fpu_operation_type;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    RESP  = 3'd3,
    DRAIN = 3'd4
  } fpu_issue_state_t;

  // Dynamic rounding-mode encoding in the instruction rm field.
  localparam logic [2:0] RM_DYN = 3'b111;

  // Operation as handed to the hub; rm is already resolved against frm.
  typedef struct packed {
    logic [63:0]       data1;
    logic [63:0]       data2;
    logic [63:0]       data3;
    fpu_operation_type op;
    logic [1:0]        fmt;
    logic [2:0]        rm;
  } fpu_hub_req_t;

  // True for operations whose funct3 field is a rounding mode.
  function automatic logic fpu_op_uses_rm(input fpu_operation_type op);
    case (op)
      FPU_FMADD, FPU_FMSUB, FPU_FNMADD, FPU_FNMSUB,
      FPU_FADD, FPU_FSUB, FPU_FMUL, FPU_FDIV, FPU_FSQRT,
      FPU_FCVT_F2I, FPU_FCVT_I2F, FPU_FCVT_F2F: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Request/result link between the issue controller (master) and fpu_hub
// (slave).
interface fpu_issue_ctrl_if;
  import fpu_issue_ctrl_pkg::*;

  logic              hub_enable;
  logic [63:0]       hub_data1;
  logic [63:0]       hub_data2;
  logic [63:0]       hub_data3;
  fpu_operation_type hub_op;
  logic [1:0]        hub_fmt;
  logic [2:0]        hub_rm;
  logic              hub_clear;
  logic [63:0]       hub_result;
  logic [4:0]        hub_flags;
  logic              hub_ready;

  modport master (
    output hub_enable, hub_data1, hub_data2, hub_data3,
           hub_op, hub_fmt, hub_rm, hub_clear,
    input  hub_result, hub_flags, hub_ready
  );

  modport slave (
    input  hub_enable, hub_data1, hub_data2, hub_data3,
           hub_op, hub_fmt, hub_rm, hub_clear,
    output hub_result, hub_flags, hub_ready
  );

endinterface

// File: rtl/fpu_issue_ctrl_rm_resolve.sv
// Rounding-mode resolution: substitutes frm for a dynamic rm on operations
// that round, and flags reserved modes on those operations. Operations that
// use funct3 for something else pass it through untouched and are never
// illegal here.
module fpu_rm_resolve
  import fpu_issue_ctrl_pkg::*;
(
  input  fpu_operation_type op,
  input  logic [2:0]        rm,
  input  logic [2:0]        frm,
  output logic [2:0]        rm_eff,
  output logic              illegal
);

  logic uses_rm;

  assign uses_rm = fpu_op_uses_rm(op);
  assign rm_eff  = (uses_rm && (rm == RM_DYN)) ? frm : rm;
  // Encodings 5..7 are reserved (7 after substitution means frm itself was DYN).
  assign illegal = uses_rm && (rm_eff >= 3'd5);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue controller: accepts one op from the issue stage, issues it to
// fpu_hub with a one-cycle enable, waits for completion (with timeout), and
// presents the result on a valid/ready writeback port. Flush kills the op;
// a flush of an op already running in the hub holds hub_clear for a fixed
// drain window so no stale completion leaks into the next op.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int TAG_W        = 5,
  parameter int TIMEOUT      = 64,
  parameter int DRAIN_CYCLES = 40
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [63:0]       req_data1,
  input  logic [63:0]       req_data2,
  input  logic [63:0]       req_data3,
  input  fpu_operation_type req_op,
  input  logic [1:0]        req_fmt,
  input  logic [2:0]        req_rm,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [2:0]        frm,
  input  logic              flush,

  fpu_issue_ctrl_if.master  hub,

  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [63:0]       wb_result,
  output logic [4:0]        wb_flags,
  output logic [TAG_W-1:0]  wb_tag,
  output logic              wb_illegal,
  output logic              wb_timeout,
  output logic              fflags_we,
  output logic [4:0]        fflags_set
);

  localparam int CNT_MAX = (TIMEOUT > DRAIN_CYCLES) ? TIMEOUT : DRAIN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_DRAIN_LAST   = CNT_W'(DRAIN_CYCLES - 1);

  fpu_issue_state_t   state;
  logic [CNT_W-1:0]   cnt;
  fpu_hub_req_t       op_q;
  logic [TAG_W-1:0]   op_tag_q;

  logic [2:0]         rs_rm_eff;
  logic               rs_illegal;

  logic               accept;
  logic               wb_hs;
  logic               in_issue;
  logic               timeout_hit;

  fpu_rm_resolve u_rm_resolve (
    .op      (req_op),
    .rm      (req_rm),
    .frm     (frm),
    .rm_eff  (rs_rm_eff),
    .illegal (rs_illegal)
  );

  // In RESP a new op can be taken in the same cycle the result is consumed.
  assign req_ready   = (state == IDLE) || ((state == RESP) && wb_ready);
  assign accept      = req_valid && req_ready && !flush;
  assign wb_hs       = (state == RESP) && wb_ready && !flush;
  assign in_issue    = (state == ISSUE);
  assign timeout_hit = (state == WAIT) && !flush && !hub.hub_ready &&
                       (cnt == CNT_TIMEOUT_LAST);

  // Hub request lines are live only during the single ISSUE cycle.
  assign hub.hub_enable = in_issue;
  assign hub.hub_data1  = in_issue ? op_q.data1 : 64'd0;
  assign hub.hub_data2  = in_issue ? op_q.data2 : 64'd0;
  assign hub.hub_data3  = in_issue ? op_q.data3 : 64'd0;
  assign hub.hub_op     = in_issue ? op_q.op    : fpu_operation_type'(5'd0);
  assign hub.hub_fmt    = in_issue ? op_q.fmt   : 2'd0;
  assign hub.hub_rm     = in_issue ? op_q.rm    : 3'd0;
  assign hub.hub_clear  = (in_issue && flush) || timeout_hit || (state == DRAIN);

  assign wb_valid   = (state == RESP);
  assign fflags_we  = wb_hs && !wb_illegal;
  assign fflags_set = wb_flags;

  // Control FSM with op and writeback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op_q       <= '0;
      op_tag_q   <= '0;
      wb_result  <= 64'd0;
      wb_flags   <= 5'd0;
      wb_tag     <= '0;
      wb_illegal <= 1'b0;
      wb_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: ;  // acceptance handled below

        ISSUE: begin
          if (flush) begin
            state <= IDLE;
          end else if (hub.hub_ready) begin
            wb_result  <= hub.hub_result;
            wb_flags   <= hub.hub_flags;
            wb_tag     <= op_tag_q;
            wb_illegal <= 1'b0;
            wb_timeout <= 1'b0;
            state      <= RESP;
          end else begin
            cnt   <= '0;
            state <= WAIT;
          end
        end

        WAIT: begin
          if (flush) begin
            cnt   <= '0;
            state <= DRAIN;
          end else if (hub.hub_ready) begin
            wb_result  <= hub.hub_result;
            wb_flags   <= hub.hub_flags;
            wb_tag     <= op_tag_q;
            wb_illegal <= 1'b0;
            wb_timeout <= 1'b0;
            state      <= RESP;
          end else if (cnt == CNT_TIMEOUT_LAST) begin
            wb_result  <= 64'd0;
            wb_flags   <= 5'd0;
            wb_tag     <= op_tag_q;
            wb_illegal <= 1'b0;
            wb_timeout <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RESP: begin
          if (flush || wb_ready) state <= IDLE;
        end

        DRAIN: begin
          if (flush) begin
            cnt <= '0;
          end else if (cnt == CNT_DRAIN_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      // A new op from IDLE or from RESP overrides the transition chosen above.
      if (accept) begin
        op_q.data1 <= req_data1;
        op_q.data2 <= req_data2;
        op_q.data3 <= req_data3;
        op_q.op    <= req_op;
        op_q.fmt   <= req_fmt;
        op_q.rm    <= rs_rm_eff;
        op_tag_q   <= req_tag;
        if (rs_illegal) begin
          wb_result  <= 64'd0;
          wb_flags   <= 5'd0;
          wb_tag     <= req_tag;
          wb_illegal <= 1'b1;
          wb_timeout <= 1'b0;
          state      <= RESP;
        end else begin
          state <= ISSUE;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: the testbench plays both the issue
// stage and fpu_hub, with hand-computed expectations.
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;

  localparam int TAG_W = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [63:0]       req_data1 = '0;
  logic [63:0]       req_data2 = '0;
  logic [63:0]       req_data3 = '0;
  fpu_operation_type req_op = FPU_FMADD;
  logic [1:0]        req_fmt = '0;
  logic [2:0]        req_rm = '0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic [2:0]        frm = '0;
  logic              flush = 1'b0;
  logic              wb_valid;
  logic              wb_ready = 1'b0;
  logic [63:0]       wb_result;
  logic [4:0]        wb_flags;
  logic [TAG_W-1:0]  wb_tag;
  logic              wb_illegal;
  logic              wb_timeout;
  logic              fflags_we;
  logic [4:0]        fflags_set;

  fpu_issue_ctrl_if hub_if ();

  fpu_issue_ctrl #(
    .TAG_W        (TAG_W),
    .TIMEOUT      (64),
    .DRAIN_CYCLES (40)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data1  (req_data1),
    .req_data2  (req_data2),
    .req_data3  (req_data3),
    .req_op     (req_op),
    .req_fmt    (req_fmt),
    .req_rm     (req_rm),
    .req_tag    (req_tag),
    .frm        (frm),
    .flush      (flush),
    .hub        (hub_if),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_result  (wb_result),
    .wb_flags   (wb_flags),
    .wb_tag     (wb_tag),
    .wb_illegal (wb_illegal),
    .wb_timeout (wb_timeout),
    .fflags_we  (fflags_we),
    .fflags_set (fflags_set)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input fpu_operation_type op, input logic [2:0] rm,
                         input logic [TAG_W-1:0] tag, input logic [63:0] d1);
    req_valid = 1'b1;
    req_op    = op;
    req_rm    = rm;
    req_tag   = tag;
    req_data1 = d1;
    req_data2 = ~d1;
    req_data3 = 64'd0;
    req_fmt   = 2'd1;
  endtask

  int en_cnt, clr_cnt, rr0_cnt, wv_cnt, clr_at;
  logic stable;

  initial begin
    hub_if.hub_ready  = 1'b0;
    hub_if.hub_result = '0;
    hub_if.hub_flags  = '0;

    // Reset values
    #2;
    check("rst_req_ready", req_ready, 1);
    check("rst_hub_enable", hub_if.hub_enable, 0);
    check("rst_hub_clear", hub_if.hub_clear, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_fflags_we", fflags_we, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // fsgnj, single-cycle completion; rm passes through despite frm=101
    frm = 3'b101;
    set_req(FPU_FSGNJ, 3'b010, 5'd3, 64'h0000_0000_0000_00A5);
    #1 check("t1_req_ready", req_ready, 1);
    cyc();
    req_valid = 1'b0;
    check("t1_hub_enable", hub_if.hub_enable, 1);
    check("t1_hub_rm", hub_if.hub_rm, 3'b010);
    check("t1_hub_data1", hub_if.hub_data1, 64'hA5);
    check("t1_wb_valid_early", wb_valid, 0);
    hub_if.hub_ready  = 1'b1;
    hub_if.hub_result = 64'h3FF0_0000_0000_0000;
    hub_if.hub_flags  = 5'd0;
    cyc();
    hub_if.hub_ready = 1'b0;
    check("t1_wb_valid", wb_valid, 1);
    check("t1_wb_result", wb_result, 64'h3FF0_0000_0000_0000);
    check("t1_wb_flags", wb_flags, 0);
    check("t1_wb_tag", wb_tag, 3);
    check("t1_hub_enable_off", hub_if.hub_enable, 0);
    wb_ready = 1'b1;
    #1 check("t1_fflags_we", fflags_we, 1);
    cyc();
    wb_ready = 1'b0;
    #1 check("t1_fflags_we_off", fflags_we, 0);
    check("t1_wb_valid_off", wb_valid, 0);
    check("t1_req_ready_idle", req_ready, 1);

    // fdiv with dynamic rm, frm=001, completion 20 cycles after ISSUE
    frm = 3'b001;
    set_req(FPU_FDIV, 3'b111, 5'd9, 64'h4000_0000_0000_0000);
    cyc();
    req_valid = 1'b0;
    check("t2_hub_rm", hub_if.hub_rm, 3'b001);
    check("t2_hub_op", hub_if.hub_op, FPU_FDIV);
    en_cnt = 0;
    for (int i = 0; i <= 20; i++) begin
      if (hub_if.hub_enable) en_cnt++;
      if (i == 19) check("t2_wb_valid_early", wb_valid, 0);
      if (i == 20) begin
        hub_if.hub_ready  = 1'b1;
        hub_if.hub_result = 64'h3FE0_0000_0000_0000;
        hub_if.hub_flags  = 5'b00001;
      end
      cyc();
    end
    hub_if.hub_ready = 1'b0;
    check("t2_enable_cycles", en_cnt, 1);
    check("t2_wb_valid", wb_valid, 1);
    check("t2_wb_flags", wb_flags, 5'b00001);
    check("t2_wb_result", wb_result, 64'h3FE0_0000_0000_0000);
    wb_ready = 1'b1;
    #1 check("t2_fflags_set", fflags_set, 5'b00001);
    cyc();
    wb_ready = 1'b0;

    // fadd with dynamic rm and frm=101 is illegal; never reaches the hub
    frm = 3'b101;
    set_req(FPU_FADD, 3'b111, 5'd4, 64'h1234);
    cyc();
    req_valid = 1'b0;
    check("t3_hub_enable", hub_if.hub_enable, 0);
    check("t3_wb_valid", wb_valid, 1);
    check("t3_wb_illegal", wb_illegal, 1);
    check("t3_wb_result", wb_result, 0);
    check("t3_wb_tag", wb_tag, 4);
    wb_ready = 1'b1;
    #1 check("t3_fflags_we", fflags_we, 0);
    cyc();
    wb_ready = 1'b0;

    // Writeback stall, then back-to-back accept in RESP
    frm = 3'b000;
    set_req(FPU_FMUL, 3'b000, 5'd7, 64'h55);
    cyc();
    req_valid = 1'b0;
    hub_if.hub_ready  = 1'b1;
    hub_if.hub_result = 64'hC000_0000_0000_0001;
    hub_if.hub_flags  = 5'b00100;
    cyc();
    hub_if.hub_result = 64'hDEAD_BEEF_DEAD_BEEF;
    hub_if.hub_flags  = 5'b11111;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (wb_valid !== 1'b1 || wb_result !== 64'hC000_0000_0000_0001 ||
          wb_flags !== 5'b00100 || wb_tag !== 5'd7) stable = 1'b0;
      cyc();
    end
    hub_if.hub_ready = 1'b0;
    check("t4_wb_stable", stable, 1);
    wb_ready = 1'b1;
    set_req(FPU_FSUB, 3'b001, 5'd8, 64'h66);
    #1 check("t4_req_ready_resp", req_ready, 1);
    check("t4_fflags_we", fflags_we, 1);
    check("t4_enable_not_yet", hub_if.hub_enable, 0);
    cyc();
    wb_ready  = 1'b0;
    req_valid = 1'b0;
    check("t4_hub_enable_next", hub_if.hub_enable, 1);
    check("t4_hub_op", hub_if.hub_op, FPU_FSUB);
    check("t4_hub_rm", hub_if.hub_rm, 3'b001);
    hub_if.hub_ready  = 1'b1;
    hub_if.hub_result = 64'h0123_4567_89AB_CDEF;
    hub_if.hub_flags  = 5'd0;
    cyc();
    hub_if.hub_ready = 1'b0;
    check("t4_wb_result2", wb_result, 64'h0123_4567_89AB_CDEF);
    check("t4_wb_tag2", wb_tag, 8);
    wb_ready = 1'b1;
    cyc();
    wb_ready = 1'b0;

    // Flush during ISSUE: clear that cycle, completion ignored, back to IDLE
    set_req(FPU_FADD, 3'b000, 5'd2, 64'h77);
    cyc();
    req_valid = 1'b0;
    flush = 1'b1;
    hub_if.hub_ready = 1'b1;
    #1 check("t5_issue_clear", hub_if.hub_clear, 1);
    cyc();
    flush = 1'b0;
    hub_if.hub_ready = 1'b0;
    #1 check("t5_issue_wb_valid", wb_valid, 0);
    check("t5_issue_req_ready", req_ready, 1);
    check("t5_issue_clear_off", hub_if.hub_clear, 0);

    // Flush during WAIT: 40-cycle drain
    set_req(FPU_FSQRT, 3'b000, 5'd5, 64'h88);
    cyc();
    req_valid = 1'b0;
    cyc(); cyc();
    flush = 1'b1;
    #1 check("t5_wait_flush_noclear", hub_if.hub_clear, 0);
    cyc();
    flush = 1'b0;
    clr_cnt = 0; rr0_cnt = 0; wv_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (hub_if.hub_clear) clr_cnt++;
      if (!req_ready) rr0_cnt++;
      if (wb_valid) wv_cnt++;
      cyc();
    end
    check("t5_drain_clear_cycles", clr_cnt, 40);
    check("t5_drain_req_ready_low", rr0_cnt, 40);
    check("t5_drain_wb_valid", wv_cnt, 0);
    check("t5_drain_req_ready", req_ready, 1);

    // Timeout: hub never answers
    set_req(FPU_FMADD, 3'b000, 5'd11, 64'h99);
    cyc();
    req_valid = 1'b0;
    cyc();
    clr_cnt = 0; clr_at = -1;
    for (int i = 0; i < 64; i++) begin
      if (hub_if.hub_clear) begin
        clr_cnt++;
        clr_at = i;
      end
      cyc();
    end
    check("t6_clear_cycles", clr_cnt, 1);
    check("t6_clear_at_cnt", clr_at, 63);
    check("t6_wb_valid", wb_valid, 1);
    check("t6_wb_timeout", wb_timeout, 1);
    check("t6_wb_result", wb_result, 0);
    check("t6_wb_tag", wb_tag, 11);
    wb_ready = 1'b1;
    #1 check("t6_fflags_set", fflags_set, 0);
    cyc();
    wb_ready = 1'b0;

    // Asynchronous reset mid-WAIT, no drain afterwards
    set_req(FPU_FDIV, 3'b000, 5'd13, 64'hAA);
    cyc();
    req_valid = 1'b0;
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    check("t7_req_ready", req_ready, 1);
    check("t7_hub_enable", hub_if.hub_enable, 0);
    check("t7_hub_clear", hub_if.hub_clear, 0);
    check("t7_wb_valid", wb_valid, 0);
    check("t7_wb_tag", wb_tag, 0);
    check("t7_wb_timeout", wb_timeout, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("t7_post_clear", hub_if.hub_clear, 0);
    check("t7_post_req_ready", req_ready, 1);
    check("t7_post_wb_valid", wb_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
